// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and operation mode for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_DIV  = 6'h03;
  localparam logic [5:0] OP_MFHI = 6'h18;
  localparam logic [5:0] OP_MFLO = 6'h19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  // Only MUL and DIV start an operation; every other opcode is ignored here.
  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the decode/ALU stage (master) and the muldiv sequencer (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] in_s1;
  logic [WIDTH-1:0] in_s2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, in_s1, in_s2, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, in_s1, in_s2, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2W-bit accumulator.
// For DIV the new quotient bit is returned separately; its slot in acc_next is left as zero.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  mode_e              mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // MUL: acc = {partial product, remaining multiplier bits}, consumed LSB first.
  // DIV: acc = {remainder, dividend bits shifting into quotient}; diff[WIDTH] is the borrow.
  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode == MODE_MUL) begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff     = shifted - {1'b0, operand};
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/DIV sequencer owning HI/LO; stalls the pipeline via busy until done.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic               accept;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode_q),
    .acc      (acc_q),
    .operand  (operand_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // A flush in the same cycle as a start cancels that start.
  assign accept = bus.start && is_muldiv_op(bus.op) && !bus.flush;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          dbz_d = 1'b0;
          if (bus.op == OP_DIV) begin
            mode_d    = MODE_DIV;
            operand_d = bus.in_s2;
            acc_d     = {{WIDTH{1'b0}}, bus.in_s1};
            // Divide by zero skips the iterations and reports a saturated quotient.
            if (bus.in_s2 == '0) begin
              state_d = ST_DONE;
              hi_d    = bus.in_s1;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            mode_d    = MODE_MUL;
            operand_d = bus.in_s1;
            acc_d     = {{WIDTH{1'b0}}, bus.in_s2};
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          // HI/LO only change on the edge into DONE so MFHI/MFLO see a stable result meanwhile.
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = ST_DONE;
            hi_d    = acc_d[2*WIDTH-1:WIDTH];
            lo_d    = acc_d[WIDTH-1:0];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MUL;
      cnt_q     <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/div_by_zero are queued at issue and checked at done.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           done_seen = 0;
  int           done_expected = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  // Independent tally of every done pulse, so extra or missing pulses show up at the end.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    bus.start = 1'b0;
    bus.op    = 6'h00;
    bus.in_s1 = '0;
    bus.in_s2 = '0;
    bus.flush = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge right after the acceptance edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] prod;
    bus.start = 1'b1;
    bus.op    = op;
    bus.in_s1 = a;
    bus.in_s2 = b;
    if (op == OP_MUL) begin
      prod  = {32'b0, a} * {32'b0, b};
      e.hi  = prod[63:32];
      e.lo  = prod[31:0];
      e.dbz = 1'b0;
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      e.hi  = a % b;
      e.lo  = a / b;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 6'($urandom_range(0, 63));
    bus.in_s1 = $urandom();
    bus.in_s2 = $urandom();
  endtask

  task automatic waitDone(input string tag, input int exp_latency);
    int   n;
    exp_t e;
    n = 0;
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && n < 40) begin
      if (n == 16) begin
        checkOutput({tag, "_hold_hi"}, 64'(bus.hi), 64'(last_hi));
        checkOutput({tag, "_hold_lo"}, 64'(bus.lo), 64'(last_lo));
      end
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checkOutput({tag, "_timeout"}, 64'(bus.done), 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      done_expected++;
      checkOutput({tag, "_latency"}, 64'(n + 1), 64'(exp_latency));
      if (sb.size() == 0) begin
        checkOutput({tag, "_sb_underflow"}, 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
        checkOutput({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int ndone;
    idleInputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_hi", 64'(bus.hi), 64'd0);
    checkOutput("rst_lo", 64'(bus.lo), 64'd0);
    checkOutput("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] multiply cases");
    applyStimulus(OP_MUL, 32'd3, 32'd5);
    waitDone("mul_3x5", W + 1);
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("mul_max", W + 1);

    $display("[TB] divide cases");
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    waitDone("div_100_7", W + 1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'd1);
    waitDone("div_msb_1", W + 1);
    applyStimulus(OP_DIV, 32'd5, 32'd0);
    waitDone("div_by_0", 1);
    applyStimulus(OP_MUL, 32'd2, 32'd2);
    checkOutput("dbz_cleared", 64'(bus.div_by_zero), 64'd0);
    waitDone("mul_2x2", W + 1);

    $display("[TB] ignored starts");
    bus.start = 1'b1; bus.op = OP_MFHI; bus.in_s1 = 32'd9; bus.in_s2 = 32'd9;
    @(negedge clk);
    idleInputs();
    checkOutput("bad_op_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1; bus.op = OP_MUL; bus.in_s1 = 32'd9; bus.in_s2 = 32'd9; bus.flush = 1'b1;
    @(negedge clk);
    idleInputs();
    checkOutput("flush_start_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);

    $display("[TB] flush during run");
    applyStimulus(OP_MUL, 32'd3, 32'd5);
    void'(sb.pop_back());
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (c == 20) checkOutput("flush_busy", 64'(bus.busy), 64'd0);
      if (c == 9) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.in_s1 = 32'd9; bus.in_s2 = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      bus.flush = (c == 19);
    end
    idleInputs();
    checkOutput("flush_no_done", 64'(ndone), 64'd0);
    checkOutput("flush_hi", 64'(bus.hi), 64'(last_hi));
    checkOutput("flush_lo", 64'(bus.lo), 64'(last_lo));
    checkOutput("flush_final_busy", 64'(bus.busy), 64'd0);

    $display("[TB] reset during divide");
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    void'(sb.pop_back());
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_done", 64'(bus.done), 64'd0);
    checkOutput("mid_rst_hi", 64'(bus.hi), 64'd0);
    checkOutput("mid_rst_lo", 64'(bus.lo), 64'd0);
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    applyStimulus(OP_MUL, 32'd6, 32'd7);
    waitDone("mul_6x7", W + 1);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("done_count", 64'(done_seen), 64'(done_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
